// File: rtl/input_buffer_ctrl_pkg.sv
// ----------------------------------------------------------------------------
// input_buffer_pkg
// Shared definitions for the line-buffer sequencing controller.
//   state_t   : controller FSM states
//   DEF_*     : default geometry (beats per line, lines per frame, buffer depth)
//   idx_w()   : width of an index counting 0..n-1. The result is never below 1
//               so that degenerate sizes still give a legal vector.
// ----------------------------------------------------------------------------
package input_buffer_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        FILL   = 3'd1,
        STREAM = 3'd2,
        FLUSH  = 3'd3,
        DONE   = 3'd4
    } state_t;

    localparam int DEF_LINE_W = 640;
    localparam int DEF_IMG_H  = 480;
    localparam int DEF_DEPTH  = 1024;

    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/input_buffer_ctrl_if.sv
// ----------------------------------------------------------------------------
// input_buffer_ctrl_if
// Handshake and strobe bundle between the controller, upstream, downstream
// and the 8-lane line-buffer array.
//   i_in_valid  : upstream beat present on all lanes
//   o_in_ready  : controller accepts a beat this cycle
//   i_stall     : downstream cannot take a read beat this cycle
//   o_lb_write  : shared line-buffer write strobe
//   o_lb_read   : shared line-buffer read strobe
//   o_out_valid : line-buffer output data valid (one cycle after o_lb_read)
//   o_col/o_row : raster position of the o_out_valid beat
// Modports: master = controller side, slave = surrounding datapath.
// ----------------------------------------------------------------------------
interface input_buffer_ctrl_if
    import input_buffer_pkg::*;
#(
    parameter int LINE_W = DEF_LINE_W,
    parameter int IMG_H  = DEF_IMG_H
);
    localparam int COL_W = idx_w(LINE_W);
    localparam int ROW_W = idx_w(IMG_H);

    logic             i_in_valid;
    logic             o_in_ready;
    logic             i_stall;
    logic             o_lb_write;
    logic             o_lb_read;
    logic             o_out_valid;
    logic [COL_W-1:0] o_col;
    logic [ROW_W-1:0] o_row;

    modport master (
        input  i_in_valid,
        input  i_stall,
        output o_in_ready,
        output o_lb_write,
        output o_lb_read,
        output o_out_valid,
        output o_col,
        output o_row
    );

    modport slave (
        output i_in_valid,
        output i_stall,
        input  o_in_ready,
        input  o_lb_write,
        input  o_lb_read,
        input  o_out_valid,
        input  o_col,
        input  o_row
    );

endinterface

// File: rtl/input_buffer_ctrl_raster_counter.sv
// ----------------------------------------------------------------------------
// raster_counter
// Column/row position counter.
//   clk, srst : clock, synchronous active-high reset
//   clr       : return to (0,0)
//   en        : advance one position; the column wraps at COLS-1 and bumps row
//   col, row  : current position (the next beat to be read)
// The row also wraps at ROWS-1 so it stays inside its range if driven past
// the last line.
// ----------------------------------------------------------------------------
module raster_counter
    import input_buffer_pkg::*;
#(
    parameter int COLS  = DEF_LINE_W,
    parameter int ROWS  = DEF_IMG_H,
    parameter int COL_W = idx_w(COLS),
    parameter int ROW_W = idx_w(ROWS)
)(
    input  logic             clk,
    input  logic             srst,
    input  logic             clr,
    input  logic             en,
    output logic [COL_W-1:0] col,
    output logic [ROW_W-1:0] row
);
    localparam logic [COL_W-1:0] COL_LAST = COL_W'(COLS - 1);
    localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(ROWS - 1);

    logic [COL_W-1:0] col_reg, col_next;
    logic [ROW_W-1:0] row_reg, row_next;

    always_comb begin
        col_next = col_reg;
        row_next = row_reg;
        if (clr) begin
            col_next = '0;
            row_next = '0;
        end else if (en) begin
            if (col_reg == COL_LAST) begin
                col_next = '0;
                row_next = (row_reg == ROW_LAST) ? '0 : row_reg + 1'b1;
            end else begin
                col_next = col_reg + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (srst) begin
            col_reg <= '0;
            row_reg <= '0;
        end else begin
            col_reg <= col_next;
            row_reg <= row_next;
        end
    end

    assign col = col_reg;
    assign row = row_reg;

endmodule

// File: rtl/input_buffer_ctrl.sv
// ----------------------------------------------------------------------------
// input_buffer_ctrl
// Lock-step sequencing controller for the 8-lane line-buffer array.
// Buffers one full line before reading, then streams reads alongside writes
// under downstream stall, and finally drains the buffer.
//   i_clk, i_rst : clock, synchronous active-high reset
//   i_start      : one-cycle frame start (only honoured in IDLE)
//   o_busy       : controller is not IDLE
//   o_done       : one-cycle frame-complete pulse, aligned with the last
//                  o_out_valid
//   bus          : handshake/strobe bundle (master side)
// ----------------------------------------------------------------------------
module input_buffer_ctrl
    import input_buffer_pkg::*;
#(
    parameter int LINE_W = DEF_LINE_W,
    parameter int IMG_H  = DEF_IMG_H,
    parameter int DEPTH  = DEF_DEPTH,
    parameter int CW     = $clog2(DEPTH + 1)
)(
    input  logic                 i_clk,
    input  logic                 i_rst,
    input  logic                 i_start,
    output logic                 o_busy,
    output logic                 o_done,
    input_buffer_ctrl_if.master  bus
);
    localparam int COL_W = idx_w(LINE_W);
    localparam int ROW_W = idx_w(IMG_H);
    localparam int TOTAL = LINE_W * IMG_H;
    localparam int TW    = $clog2(TOTAL + 1);

    localparam logic [CW-1:0] DEPTH_C  = CW'(DEPTH);
    localparam logic [CW-1:0] LINE_C   = CW'(LINE_W);
    localparam logic [TW-1:0] TOTAL_C  = TW'(TOTAL);
    localparam logic [TW-1:0] LAST_C   = TW'(TOTAL - 1);

    // A line must fit in one buffer, otherwise FILL could never complete.
    if (LINE_W > DEPTH) begin : g_bad_geometry
        $error("input_buffer_ctrl: LINE_W (%0d) exceeds DEPTH (%0d)", LINE_W, DEPTH);
    end

    state_t           state_reg, state_next;
    logic [CW-1:0]    occ_reg,   occ_next;
    logic [TW-1:0]    wr_cnt_reg, wr_cnt_next;
    logic [TW-1:0]    rd_cnt_reg, rd_cnt_next;
    logic             out_valid_reg;
    logic [COL_W-1:0] col_reg;
    logic [ROW_W-1:0] row_reg;

    logic             in_ready;
    logic             accept;
    logic             lb_read;
    logic             frame_clr;
    logic [COL_W-1:0] rc_col;
    logic [ROW_W-1:0] rc_row;

    // ------------------------------------------------------------------
    // Strobes: combinational from registered state/counters. in_ready
    // deliberately does not look at i_stall.
    // ------------------------------------------------------------------
    always_comb begin
        in_ready  = ((state_reg == FILL) || (state_reg == STREAM))
                    && (occ_reg < DEPTH_C) && (wr_cnt_reg < TOTAL_C);
        accept    = bus.i_in_valid & in_ready;
        lb_read   = ((state_reg == STREAM) || (state_reg == FLUSH))
                    && (occ_reg != '0) && !bus.i_stall;
        frame_clr = (state_reg == IDLE) && i_start;
    end

    // Occupancy holds when a write and a read coincide.
    always_comb begin
        occ_next    = occ_reg;
        wr_cnt_next = wr_cnt_reg;
        rd_cnt_next = rd_cnt_reg;
        if (frame_clr) begin
            occ_next    = '0;
            wr_cnt_next = '0;
            rd_cnt_next = '0;
        end else begin
            case ({accept, lb_read})
                2'b10:   occ_next = occ_reg + 1'b1;
                2'b01:   occ_next = occ_reg - 1'b1;
                default: occ_next = occ_reg;
            endcase
            if (accept)  wr_cnt_next = wr_cnt_reg + 1'b1;
            if (lb_read) rd_cnt_next = rd_cnt_reg + 1'b1;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic. The final write takes priority over the
    // line-full condition so a one-line frame goes straight to FLUSH.
    // ------------------------------------------------------------------
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE: begin
                if (i_start) state_next = FILL;
            end
            FILL: begin
                if (accept && (wr_cnt_reg == LAST_C))
                    state_next = FLUSH;
                else if (occ_next == LINE_C)
                    state_next = STREAM;
            end
            STREAM: begin
                if (accept && (wr_cnt_reg == LAST_C))
                    state_next = FLUSH;
            end
            FLUSH: begin
                if (lb_read && (rd_cnt_reg == LAST_C))
                    state_next = DONE;
            end
            DONE: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_reg  <= IDLE;
            occ_reg    <= '0;
            wr_cnt_reg <= '0;
            rd_cnt_reg <= '0;
        end else begin
            state_reg  <= state_next;
            occ_reg    <= occ_next;
            wr_cnt_reg <= wr_cnt_next;
            rd_cnt_reg <= rd_cnt_next;
        end
    end

    // Read-side raster position: points at the beat the next read fetches.
    raster_counter #(
        .COLS  (LINE_W),
        .ROWS  (IMG_H),
        .COL_W (COL_W),
        .ROW_W (ROW_W)
    ) u_rd_raster (
        .clk  (i_clk),
        .srst (i_rst),
        .clr  (frame_clr),
        .en   (lb_read),
        .col  (rc_col),
        .row  (rc_row)
    );

    // The buffer answers one cycle after the read strobe, so valid and the
    // position of the fetched beat are delayed to line up with the data.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            out_valid_reg <= 1'b0;
            col_reg       <= '0;
            row_reg       <= '0;
        end else begin
            out_valid_reg <= lb_read;
            if (frame_clr) begin
                col_reg <= '0;
                row_reg <= '0;
            end else if (lb_read) begin
                col_reg <= rc_col;
                row_reg <= rc_row;
            end
        end
    end

    assign bus.o_in_ready  = in_ready;
    assign bus.o_lb_write  = accept;
    assign bus.o_lb_read   = lb_read;
    assign bus.o_out_valid = out_valid_reg;
    assign bus.o_col       = col_reg;
    assign bus.o_row       = row_reg;
    assign o_busy          = (state_reg != IDLE);
    assign o_done          = (state_reg == DONE);

endmodule

// File: tb/tb_input_buffer_ctrl.sv
// ----------------------------------------------------------------------------
// tb_input_buffer_ctrl
// Directed bench for input_buffer_ctrl with LINE_W=4, IMG_H=3, DEPTH=8.
// Inputs change 1 ns after the rising edge; outputs are sampled on the
// falling edge. Cycle k=0 is the first cycle after the i_start edge.
// ----------------------------------------------------------------------------
module tb_input_buffer_ctrl;
    localparam int LINE_W = 4;
    localparam int IMG_H  = 3;
    localparam int DEPTH  = 8;
    localparam int TOTAL  = LINE_W * IMG_H;

    logic clk = 1'b0;
    logic i_rst;
    logic i_start;
    logic o_busy;
    logic o_done;

    input_buffer_ctrl_if #(.LINE_W(LINE_W), .IMG_H(IMG_H)) bus ();

    input_buffer_ctrl #(
        .LINE_W (LINE_W),
        .IMG_H  (IMG_H),
        .DEPTH  (DEPTH)
    ) dut (
        .i_clk   (clk),
        .i_rst   (i_rst),
        .i_start (i_start),
        .o_busy  (o_busy),
        .o_done  (o_done),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    // Per-frame statistics gathered by run_frame.
    int n_wr, n_rd, n_ov, n_both, n_done;
    int c4, first_rd, done_k, occ, occ_max, occ_min;

    task automatic check_eq(input string tag, input int got, input int exp);
        n_checks++;
        if (got != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    task automatic start_frame();
        i_start        = 1'b1;
        bus.i_in_valid = 1'b0;
        bus.i_stall    = 1'b0;
        @(posedge clk); #1;
        i_start = 1'b0;
    endtask

    // Runs one frame to completion. Stall is held for the first
    // stall_cycles cycles, valid drops for gap_len cycles from gap_at,
    // and i_start is re-pulsed at cycle start_at (if >= 0).
    task automatic run_frame(input string name, input int stall_cycles,
                             input int gap_at, input int gap_len,
                             input int start_at);
        bit finished;
        n_wr = 0; n_rd = 0; n_ov = 0; n_both = 0; n_done = 0;
        c4 = -1; first_rd = -1; done_k = -1;
        occ = 0; occ_max = 0; occ_min = 0;
        finished = 1'b0;
        for (int k = 0; k < 200 && !finished; k++) begin
            bus.i_stall    = (k < stall_cycles);
            bus.i_in_valid = !(k >= gap_at && k < gap_at + gap_len);
            i_start        = (k == start_at);
            @(negedge clk);
            if (done_k >= 0 && k == done_k + 1) begin
                check_eq({name, "_busy_after_done"}, o_busy, 0);
                finished = 1'b1;
            end
            if (bus.o_lb_write) begin
                n_wr++;
                if (n_wr == LINE_W) c4 = k;
            end
            if (bus.o_lb_read) begin
                n_rd++;
                if (first_rd < 0) first_rd = k;
            end
            if (bus.o_lb_write && bus.o_lb_read) n_both++;
            occ = occ + int'(bus.o_lb_write) - int'(bus.o_lb_read);
            if (occ > occ_max) occ_max = occ;
            if (occ < occ_min) occ_min = occ;
            if (bus.o_out_valid) begin
                $display("%s beat %0d: col=%0d row=%0d", name, n_ov, bus.o_col, bus.o_row);
                check_eq({name, "_col"}, bus.o_col, n_ov % LINE_W);
                check_eq({name, "_row"}, bus.o_row, n_ov / LINE_W);
                n_ov++;
            end
            if (o_done) begin
                n_done++;
                done_k = k;
                check_eq({name, "_done_with_valid"}, bus.o_out_valid, 1);
                check_eq({name, "_busy_at_done"}, o_busy, 1);
            end
            if (gap_len > 0 && k >= gap_at + LINE_W && k < gap_at + gap_len)
                check_eq({name, "_gap_no_read"}, bus.o_lb_read, 0);
            if (gap_len > 0 && k == gap_at + gap_len) begin
                check_eq({name, "_resume_write"}, bus.o_lb_write, 1);
                check_eq({name, "_resume_no_read"}, bus.o_lb_read, 0);
            end
            if (stall_cycles > 2 * LINE_W && k == stall_cycles - 1) begin
                check_eq({name, "_stall_ready_low"}, bus.o_in_ready, 0);
                check_eq({name, "_stall_writes"}, n_wr, DEPTH);
            end
            @(posedge clk); #1;
        end
        i_start = 1'b0;
        if (!finished) check_eq({name, "_frame_timeout"}, 0, 1);
        check_eq({name, "_writes"}, n_wr, TOTAL);
        check_eq({name, "_reads"}, n_rd, TOTAL);
        check_eq({name, "_out_valid"}, n_ov, TOTAL);
        check_eq({name, "_done_count"}, n_done, 1);
        check_eq({name, "_occ_min"}, occ_min, 0);
        $display("%s: frame complete, writes=%0d reads=%0d max_occ=%0d", name, n_wr, n_rd, occ_max);
    endtask

    initial begin
        i_rst          = 1'b1;
        i_start        = 1'b0;
        bus.i_in_valid = 1'b0;
        bus.i_stall    = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check_eq("rst_busy", o_busy, 0);
        check_eq("rst_done", o_done, 0);
        check_eq("rst_in_ready", bus.o_in_ready, 0);
        check_eq("rst_out_valid", bus.o_out_valid, 0);
        check_eq("rst_col", bus.o_col, 0);
        check_eq("rst_row", bus.o_row, 0);
        i_rst = 1'b0;
        @(posedge clk); #1;

        // Free-running frame: fill k0..3, stream k4..11, flush k12..15, done k16.
        start_frame();
        run_frame("basic", 0, 1000, 0, -1);
        check_eq("basic_4th_accept", c4, 3);
        check_eq("basic_first_read", first_rd, 4);
        check_eq("basic_both_strobes", n_both, 8);
        check_eq("basic_occ_max", occ_max, LINE_W);
        check_eq("basic_done_cycle", done_k, 16);

        // Stall held for 20 cycles: buffer fills to DEPTH and ready drops.
        start_frame();
        run_frame("stall", 20, 1000, 0, -1);
        check_eq("stall_occ_max", occ_max, DEPTH);

        // 6-cycle upstream gap at k6: drains to 0 by k10, resumes at k12.
        start_frame();
        run_frame("gap", 0, 6, 6, -1);
        check_eq("gap_both_strobes", n_both, 7);

        // i_start re-pulsed in STREAM must be ignored.
        start_frame();
        run_frame("restart", 0, 1000, 0, 6);
        check_eq("restart_done_cycle", done_k, 16);

        // Reset mid-STREAM with a read in flight (read at k5).
        start_frame();
        bus.i_in_valid = 1'b1;
        repeat (6) @(posedge clk);
        #1;
        i_rst = 1'b1;
        @(posedge clk); #1;
        check_eq("midrst_out_valid", bus.o_out_valid, 0);
        check_eq("midrst_busy", o_busy, 0);
        check_eq("midrst_in_ready", bus.o_in_ready, 0);
        check_eq("midrst_lb_read", bus.o_lb_read, 0);
        check_eq("midrst_lb_write", bus.o_lb_write, 0);
        check_eq("midrst_col", bus.o_col, 0);
        check_eq("midrst_row", bus.o_row, 0);
        i_rst = 1'b0;
        bus.i_in_valid = 1'b0;
        @(posedge clk); #1;
        start_frame();
        run_frame("post_reset", 0, 1000, 0, -1);
        check_eq("post_reset_first_read", first_rd, 4);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
